// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity encodings, bit-period helper.
// Used by both the transmitter and the receiver so bit timing always agrees.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int clks_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmit-side bundle: byte request in, serial line and frame status out.
// master = client requesting bytes, slave = the transmitter.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (output tx_start, output tx_data, input tx, input tx_busy, input tx_done);
    modport slave  (input tx_start, input tx_data, output tx, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period clock enable: tick is high for one clk every CLKS_PER_BIT cycles.
// clear holds the count at zero so the first period after clear is a full one.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int freq      = 100_000_000,
    parameter int baud_rate = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CPB = clks_per_bit(freq, baud_rate);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter, optional parity, 1 or 2 stop bits; tx falls on the edge after accept.
// Requests while busy are dropped; a held tx_start is re-accepted in the single idle cycle after tx_done.
module uart_tx
    import uart_pkg::*;
#(
    parameter int freq      = 100_000_000,
    parameter int baud_rate = 9600,
    parameter int parity    = 0,
    parameter int stop_bits = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_if.slave      bus
);

    if (!(parity == PAR_NONE || parity == PAR_EVEN || parity == PAR_ODD)) begin : g_bad_parity
        $error("uart_tx: parity must be 0 (none), 1 (even) or 2 (odd)");
    end
    if (!(stop_bits == 1 || stop_bits == 2)) begin : g_bad_stop
        $error("uart_tx: stop_bits must be 1 or 2");
    end

    localparam logic HAS_PAR   = (parity != PAR_NONE);
    localparam logic ODD_PAR   = (parity == PAR_ODD);
    localparam logic STOP_LAST = (stop_bits == 2);

    uart_tx_state_t state;
    logic [7:0]     shreg;
    logic [2:0]     bit_idx;
    logic           stop_idx;
    logic           par_bit;
    logic           tx_q;
    logic           busy_q;
    logic           done_q;
    logic           tick;
    logic           timer_clear;

    // Timer sits at zero while idle, so START always gets a full bit period.
    assign timer_clear = (state == IDLE);

    uart_baud_gen #(
        .freq      (freq),
        .baud_rate (baud_rate)
    ) u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tx_start) begin
                        shreg    <= bus.tx_data;
                        par_bit  <= (^bus.tx_data) ^ ODD_PAR;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q  <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= HAS_PAR ? par_bit : 1'b1;
                            state <= HAS_PAR ? PARITY : STOP;
                        end else begin
                            tx_q    <= shreg[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_idx == STOP_LAST) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule
